rdl_reg_bus_ctrl: RTL and testbench
===================================

# rdl_reg_bus_ctrl

- Sequences CPU accesses onto a bank of `rdl_subreg` instances.
- Accepts one request at a time on a simple req/gnt/rvalid/rready bus and decodes the word address to a register index.
- Drives one-cycle write-enable and read-strobe pulses plus shared write data into the bank.
- Captures the selected `qs` and returns it with an error flag.
- Sits between the bus adapter and the generated register block.

## Interface

Parameters:
- `DW`, 32: register and bus data width; multiple of 8.
- `AW`, 8: byte address width.
- `NumRegs`, 4: number of registers; register i sits at byte offset i*(DW/8).

Ports:
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-low reset.
- `req` input 1: request valid.
- `we` input 1: 1 = write, 0 = read.
- `addr` input AW: byte address.
- `wdata` input DW: write data.
- `gnt` output 1: request accepted this cycle.
- `rvalid` output 1: response valid.
- `rready` input 1: response accepted.
- `rdata` output DW: read data; 0 for writes and errors.
- `err` output 1: response error flag, valid with `rvalid`.
- `reg_we` output NumRegs: one-hot write pulse to the subreg `we` inputs.
- `reg_re` output NumRegs: one-hot read-side-effect strobe (feeds `qe` logic for OnRead registers).
- `reg_wd` output DW: write data broadcast to all subreg `wd` inputs.
- `reg_qs` input NumRegs*DW: concatenated subreg `qs`; register i is at `[i*DW +: DW]`.

## Operation

State machine: IDLE, ACCESS, RESP.
- IDLE: `gnt = req`. On `req`, register `we`/`wdata`/decoded index/error, then go to ACCESS.
- ACCESS, one cycle:
  - Valid write: `reg_we[idx]=1`, `reg_wd=wdata`.
  - Valid read: `reg_re[idx]=1`; `rdata` is captured from `reg_qs[idx]` at the end of the cycle.
  - Error access: no pulses.
  - Always go to RESP.
- RESP: `rvalid=1` with stable `rdata`/`err` until `rvalid && rready`, then go to IDLE. `gnt=0` in ACCESS and RESP.

Decode:
- `idx = addr[AW-1:log2(DW/8)]`.
- Error when `idx >= NumRegs` or `addr[log2(DW/8)-1:0] != 0`; see Configuration.
- Error read: `rdata=0`. Error write: no side effect.

Pulses:
- `reg_we` and `reg_re` are registered and never asserted in IDLE or RESP.
- At most one bit of each is set, and never both in the same cycle.
- `reg_wd` holds the last write data, and is 0 after reset.

## Timing

- Request accepted at edge T (cycle T has `req && gnt`).
- Cycle T+1: ACCESS pulse.
- Cycle T+2: `rvalid` rises at the earliest.
- Write data lands in the subreg flop at the end of T+1, so `qs` shows it from T+2.
- Minimum issue interval is 3 cycles with `rready` held high.
- Reset values: `gnt=0` while `req=0`, `rvalid=0`, `rdata=0`, `err=0`, `reg_we=0`, `reg_re=0`, `reg_wd=0`, state IDLE.
- Reset asserted mid-transaction aborts it:
  - The state goes to IDLE and any pending response is dropped.
  - If reset hits during ACCESS, the pulse is cut off asynchronously.
- `req` held during RESP is not granted until the cycle after the handshake, i.e. when the state is back in IDLE.
- `rready` high before `rvalid` has no effect.

## Configuration

Macro `RDL_BUS_CTRL_ADDR_CHECK_EN`:
- Defined: misaligned addresses and `idx >= NumRegs` give `err=1` with no register pulse.
- Not defined:
  - Low address bits are ignored.
  - `idx` wraps modulo the next power of two of NumRegs.
  - Indices at or above NumRegs still produce no pulse, and return `rdata=0` with `err=0`.
  - `err` is tied to 0.

## Structure

- Shared package `rdl_subreg_pkg` gets:
  - `ctrl_state_e` (IDLE, ACCESS, RESP);
  - the function `rdl_addr_lsb(DW)` returning log2(DW/8).
- Sub-module `rdl_reg_decode` is purely combinational: addr -> idx, hit, err. It is reused by future multi-bank controllers.
- Top holds the FSM, capture registers and pulse registers.

## Test plan

- **Write then read:** DW=32, NumRegs=4, write 0xDEADBEEF to addr 0x08.
  - `reg_we=4'b0100` for exactly one cycle at T+1; `rvalid` at T+2 with `err=0`.
  - Reading 0x08 then returns 0xDEADBEEF.
- **Read strobe and backpressure:** read addr 0x04 with `rready=0` for 5 cycles.
  - `reg_re=4'b0010` pulses once.
  - `rvalid` and `rdata` hold for all 5 cycles; IDLE follows the handshake.
  - `gnt` stays 0 throughout even though `req` is held.
- **Unmapped access (macro defined):** write to 0x10 and read from 0x02.
  - Both give `err=1` and no `reg_we`/`reg_re`; the read returns `rdata=0`.
- **Unmapped access (macro undefined):** same stimulus.
  - 0x10 gives `err=0` and no pulse.
  - 0x02 reads register 0 with `err=0`.
- **Back-to-back:** `req` held high for 4 transactions with `rready=1`.
  - Grants land exactly every 3 cycles; responses come back in order.
- **Reset mid-ACCESS:** assert `rst=0` during ACCESS of a write.
  - `reg_we` drops immediately and `rvalid` stays 0.
  - After release the state is IDLE and the next request is granted in its first cycle.

Source files
------------

// File: rtl/rdl_subreg_pkg.sv
// Shared types and helpers for the register-bank controller and decoder.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package rdl_subreg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } ctrl_state_e;

    // Number of byte-offset bits below the word index for a DW-bit register.
    function automatic int rdl_addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/rdl_reg_decode.sv
// Word-address decoder: byte address -> register index, hit and error flags.
// Latency: combinational. Backpressure: none.
// RDL_BUS_CTRL_ADDR_CHECK_EN enables misalignment and range errors.
module rdl_reg_decode
    import rdl_subreg_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int NumRegs = 4,
    parameter int IdxW    = $clog2(NumRegs + 1)
) (
    input  logic [AW-1:0]   addr,
    output logic [IdxW-1:0] idx,
    output logic            hit,
    output logic            err
);

    localparam int Lsb = rdl_addr_lsb(DW);

`ifdef RDL_BUS_CTRL_ADDR_CHECK_EN
    localparam logic [AW-1:0] LowMask = AW'((1 << Lsb) - 1);

    logic [AW-1:0] word_addr;
    assign word_addr = addr >> Lsb;

    always_comb begin
        err = (|(addr & LowMask)) || (32'(word_addr) >= NumRegs);
        hit = !err;
        idx = word_addr[IdxW-1:0];
    end
`else
    // Index wraps modulo the power of two above NumRegs, so the top slots
    // stay unmapped and answer silently with zero data.
    always_comb begin
        idx = IdxW'(addr >> Lsb);
        hit = 32'(idx) < NumRegs;
        err = 1'b0;
    end
`endif

endmodule

// File: rtl/rdl_reg_bus_ctrl.sv
// Sequences single CPU accesses onto a subreg bank via registered we/re pulses.
// Latency: grant at T, pulse at T+1, response from T+2. Backpressure: holds RESP until rready.
// RDL_BUS_CTRL_ADDR_CHECK_EN (in rdl_reg_decode) turns unmapped accesses into errors.
module rdl_reg_bus_ctrl
    import rdl_subreg_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int NumRegs = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DW-1:0]         wdata,
    output logic                  gnt,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DW-1:0]         rdata,
    output logic                  err,
    output logic [NumRegs-1:0]    reg_we,
    output logic [NumRegs-1:0]    reg_re,
    output logic [DW-1:0]         reg_wd,
    input  logic [NumRegs*DW-1:0] reg_qs
);

    localparam int IdxW = $clog2(NumRegs + 1);

    ctrl_state_e state, state_nxt;

    logic [IdxW-1:0]    dec_idx;
    logic               dec_hit;
    logic               dec_err;
    logic [NumRegs-1:0] dec_onehot;
    logic               accept;

    logic [IdxW-1:0]    idx_q;
    logic               we_q;
    logic               hit_q;
    logic               err_q;
    logic [DW-1:0]      rdata_q;
    logic [DW-1:0]      qs_sel;

    rdl_reg_decode #(
        .DW      (DW),
        .AW      (AW),
        .NumRegs (NumRegs),
        .IdxW    (IdxW)
    ) u_decode (
        .addr (addr),
        .idx  (dec_idx),
        .hit  (dec_hit),
        .err  (dec_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        unique case (state)
            IDLE: begin
                gnt = req;
                if (req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = req && gnt;

    always_comb begin
        dec_onehot = '0;
        qs_sel     = '0;
        for (int i = 0; i < NumRegs; i++) begin
            dec_onehot[i] = dec_hit && (dec_idx == IdxW'(i));
            if (idx_q == IdxW'(i)) begin
                qs_sel = reg_qs[i*DW +: DW];
            end
        end
    end

    // Pulses are launched from the accept edge so they are flop outputs that
    // live for exactly the ACCESS cycle; async reset cuts them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_we  <= '0;
            reg_re  <= '0;
            reg_wd  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            reg_we <= '0;
            reg_re <= '0;
            if (accept) begin
                idx_q <= dec_idx;
                we_q  <= we;
                hit_q <= dec_hit;
                err_q <= dec_err;
                if (we) begin
                    reg_wd <= wdata;
                    reg_we <= dec_onehot;
                end else begin
                    reg_re <= dec_onehot;
                end
            end
            if (state == ACCESS) begin
                rdata_q <= (hit_q && !we_q) ? qs_sel : '0;
            end
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rdl_reg_bus_ctrl.sv
// Self-checking bench for rdl_reg_bus_ctrl with a behavioural subreg bank.
// Expected pulses and responses are queued at grant and checked as the DUT produces them.
module tb_rdl_reg_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req = 1'b0;
    logic               we = 1'b0;
    logic [AW-1:0]      addr = '0;
    logic [DW-1:0]      wdata = '0;
    logic               gnt;
    logic               rvalid;
    logic               rready = 1'b1;
    logic [DW-1:0]      rdata;
    logic               err;
    logic [NR-1:0]      reg_we;
    logic [NR-1:0]      reg_re;
    logic [DW-1:0]      reg_wd;
    logic [NR*DW-1:0]   reg_qs;

    logic [DW-1:0] bank [NR];
    logic [DW-1:0] model_regs [NR];
    resp_t         resp_q [$];

    int n_chk = 0;
    int n_fail = 0;
    int cycle = 0;
    int last_gnt = 0;
    bit b2b = 1'b0;
    bit have_last = 1'b0;
    bit acc_pend = 1'b0;
    bit acc_pend2 = 1'b0;
    logic [NR-1:0] exp_we;
    logic [NR-1:0] exp_re;
    logic [DW-1:0] exp_wd;
    bit            exp_wr;
    int            m_idx;
    bit            m_hit;
    bit            m_err;
    resp_t         m_resp;
    resp_t         m_pop;

    rdl_reg_bus_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .NumRegs (NR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .err    (err),
        .reg_we (reg_we),
        .reg_re (reg_re),
        .reg_wd (reg_wd),
        .reg_qs (reg_qs)
    );

    always #5 clk = ~clk;

    // Stand-in for the generated subreg bank: plain storage flops.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NR; i++) if (reg_we[i]) bank[i] <= reg_wd;
        end
    end

    always_comb begin
        reg_qs = '0;
        for (int i = 0; i < NR; i++) reg_qs[i*DW +: DW] = bank[i];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void exp_decode(input logic [AW-1:0] a, output int idx,
                                       output bit hit, output bit er);
        int full;
        full = int'(a) / 4;
`ifdef RDL_BUS_CTRL_ADDR_CHECK_EN
        er  = (a[1:0] != 2'b00) || (full >= NR);
        hit = !er;
        idx = full;
`else
        er  = 1'b0;
        idx = full % 8;
        hit = idx < NR;
`endif
    endfunction

    // Monitor: pulse timing at T+1/T+2, response scoreboard, grant spacing.
    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            acc_pend  = 1'b0;
            acc_pend2 = 1'b0;
            resp_q.delete();
            for (int i = 0; i < NR; i++) model_regs[i] = '0;
        end else begin
            if (acc_pend2) begin
                chk("rvalid_at_t2", rvalid, 1);
                chk("reg_we_single", reg_we, 0);
                chk("reg_re_single", reg_re, 0);
                acc_pend2 = 1'b0;
            end
            if (acc_pend) begin
                chk("reg_we_pulse", reg_we, exp_we);
                chk("reg_re_pulse", reg_re, exp_re);
                if (exp_wr) chk("reg_wd", reg_wd, exp_wd);
                acc_pend  = 1'b0;
                acc_pend2 = 1'b1;
            end
            if (rvalid && rready) begin
                chk("resp_expected", resp_q.size() != 0, 1);
                if (resp_q.size() != 0) begin
                    m_pop = resp_q.pop_front();
                    chk("rdata", rdata, m_pop.rdata);
                    chk("err", err, m_pop.err);
                end
            end
            if (req && gnt) begin
                if (b2b && have_last) chk("grant_interval", cycle - last_gnt, 3);
                have_last = 1'b1;
                last_gnt  = cycle;
                exp_decode(addr, m_idx, m_hit, m_err);
                exp_we = '0;
                exp_re = '0;
                exp_wr = we;
                exp_wd = wdata;
                m_resp.err   = m_err;
                m_resp.rdata = '0;
                if (m_hit) begin
                    if (we) begin
                        exp_we[m_idx]     = 1'b1;
                        model_regs[m_idx] = wdata;
                    end else begin
                        exp_re[m_idx] = 1'b1;
                        m_resp.rdata  = model_regs[m_idx];
                    end
                end
                resp_q.push_back(m_resp);
                acc_pend = 1'b1;
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit granted;
        granted = 1'b0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        for (int i = 0; i < 40 && !granted; i++) begin
            @(negedge clk);
            granted = gnt;
        end
        chk("grant_seen", granted, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || acc_pend || acc_pend2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < 50, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete by time %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_re", reg_re, 0);
        chk("rst_reg_wd", reg_wd, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Write then read back register 2.
        issue(1'b1, 8'h08, 32'hDEAD_BEEF);
        req = 1'b0;
        wait_idle();
        issue(1'b0, 8'h08, '0);
        req = 1'b0;
        wait_idle();

        // Read register 1 under backpressure with req held throughout.
        issue(1'b1, 8'h04, 32'h1234_5678);
        req = 1'b0;
        wait_idle();
        rready = 1'b0;
        issue(1'b0, 8'h04, '0);
        @(negedge clk);
        chk("bp_gnt_access", gnt, 0);
        chk("bp_reg_re", reg_re, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'h1234_5678);
            chk("bp_gnt", gnt, 0);
            chk("bp_reg_re_quiet", reg_re, 0);
        end
        @(posedge clk);
        #1 rready = 1'b1;
        @(negedge clk);
        chk("bp_gnt_handshake", gnt, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_regrant", gnt, 1);
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle();

        // Unmapped and misaligned accesses.
        issue(1'b1, 8'h00, 32'hA5A5_0001);
        req = 1'b0;
        wait_idle();
        issue(1'b1, 8'h10, 32'hCAFE_F00D);
        req = 1'b0;
        wait_idle();
        issue(1'b0, 8'h02, '0);
        req = 1'b0;
        wait_idle();
        issue(1'b0, 8'h10, '0);
        req = 1'b0;
        wait_idle();

        // Back-to-back with req held high.
        b2b       = 1'b1;
        have_last = 1'b0;
        issue(1'b1, 8'h00, 32'h1111_0000);
        issue(1'b0, 8'h00, '0);
        issue(1'b1, 8'h0C, 32'h3333_CCCC);
        issue(1'b0, 8'h0C, '0);
        req = 1'b0;
        wait_idle();
        b2b = 1'b0;

        // Reset during the ACCESS cycle of a write.
        issue(1'b1, 8'h0C, 32'h5555_AAAA);
        req = 1'b0;
        #2;
        chk("mid_rst_we_before", reg_we, 4'b1000);
        rst = 1'b0;
        #1;
        chk("mid_rst_we_cut", reg_we, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_hold_rvalid", rvalid, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", rvalid, 0);
        @(posedge clk);
        #1;
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'h0C;
        @(negedge clk);
        chk("post_rst_first_gnt", gnt, 1);
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle();

        // Random traffic across mapped, unmapped and misaligned addresses.
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
            req = 1'b0;
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
